serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  augend, captured on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  addend, captured on an accepted start.
REQ-007 SHALL have port busy  output  1  high in SHIFT and DONE states.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking a completed result.
REQ-009 SHALL have port sum  output  WIDTH  result bits, held stable from done until the next accepted start.
REQ-010 SHALL have port carry_out  output  1  unsigned carry from the MSB, held with sum.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, SHALL capture a and b into shift registers, clear the carry flop, clear the bit counter and go to SHIFT.
REQ-013 In IDLE with start=0, SHALL remain in IDLE with sum and carry_out unchanged.
REQ-014 Each SHIFT cycle SHALL add the operand LSBs and the carry flop, shift the sum bit into the result MSB, right-shift both operands, update carry and increment the counter.
REQ-015 After exactly WIDTH SHIFT cycles SHALL go to DONE, and SHALL return from DONE to IDLE after one cycle.
REQ-016 done SHALL be high only in DONE; start accepted at edge T gives done high in cycle T+WIDTH+1.
REQ-017 start asserted in SHIFT or DONE SHALL be ignored and not queued; a and b SHALL be don't-care outside an accepted start.
REQ-018 The result SHALL equal (a+b) mod 2^WIDTH, and carry_out SHALL equal bit WIDTH of a+b.
REQ-019 Zero operands SHALL still take the full WIDTH cycles.

Reset
REQ-020 rst=1 SHALL force IDLE, clear busy, done, sum, carry_out, the counter and all internal flops on the next edge, in any state.
REQ-021 A reset during SHIFT SHALL abort the operation with no done pulse.
REQ-022 rst SHALL take priority over start in the same cycle.

Configuration
REQ-023 With macro SERIAL_ADDER_OVF_EN defined, SHALL add output port overflow  output  1, equal to the signed overflow (carry into MSB xor carry out of MSB), held with sum and reset to 0.
REQ-024 Without SERIAL_ADDER_OVF_EN, the overflow port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-026 The bit-level add SHALL be a sub-module full_adder (inputs a, b, cin; outputs s, cout), instantiated once.
REQ-027 The counter width SHALL be $clog2(WIDTH+1) bits.

Verification
REQ-028 WIDTH=8, a=200, b=100, start pulse -> done exactly 9 cycles later, sum=44, carry_out=1.
REQ-029 WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, carry_out=1, overflow=0 (macro on); a=0x64, b=0x64 -> sum=0xC8, carry_out=0, overflow=1.
REQ-030 start held high continuously with a=3, b=4 -> one result (sum=7) per 10 cycles; start during busy is not registered; sum is stable between dones.
REQ-031 rst asserted on the 4th SHIFT cycle of 200+100 -> next cycle busy=0, sum=0, carry_out=0, and no done pulse follows.
REQ-032 Random sweep at WIDTH=4 and WIDTH=16, 1000 operand pairs -> {carry_out,sum} equals a+b every time; done is a single-cycle pulse.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder: the controller state
// encoding and the default operand width.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN (see serial_adder.sv).
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder
// Single-bit full adder used as the arithmetic core of serial_adder.
//
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit
//   cout  - carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial unsigned adder. An accepted start captures a and b, then one
// operand bit pair is added per clock, LSB first, through a single full
// adder. After WIDTH shift cycles the result is published on sum/carry_out
// and done pulses for one cycle. The published result stays put until the
// next operation finishes, so it is stable between consecutive done pulses.
//
// Parameters:
//   WIDTH      - operand/result width, 2..32
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - begin an addition (only honoured in IDLE)
//   a, b       - operands, captured on an accepted start
//   busy       - high in SHIFT and DONE
//   done       - one-cycle pulse when a result is published
//   sum        - (a+b) mod 2^WIDTH
//   carry_out  - bit WIDTH of a+b
//   overflow   - signed overflow, only when SERIAL_ADDER_OVF_EN is defined
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  // Holds the low-order result bits produced so far; the MSB of the final
  // result comes straight from the adder on the last shift cycle.
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_c;
  logic             last_bit;
  logic [WIDTH-1:0] result;

  full_adder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign result   = {bit_s, acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. The published sum/carry_out are loaded only on the final
  // shift, so they never show partial results.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          op_a  <= {1'b0, op_a[WIDTH-1:1]};
          op_b  <= {1'b0, op_b[WIDTH-1:1]};
          acc   <= result[WIDTH-1:1];
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum       <= result;
            carry_out <= bit_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last shift the carry flop holds the carry into the MSB and the
  // adder produces the carry out of it; their xor is the signed overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      overflow <= carry ^ bit_c;
    end
  end
`endif

endmodule
